ram_access_ctrl: RTL and testbench

//  Multi-cycle sequencer that drives the control word of the RAM datapath.

---
 rtl/ram_access_ctrl_pkg.sv | 50 +++++
 rtl/ram_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared encodings for the RAM access sequencer: opcodes, FSM states,
// latched command and control-word bundles.
package ram_access_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ALU_R = 2'b00,
        OP_ALU_I = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_ADDR,
        S_MEM,
        S_DONE
    } state_t;

    localparam logic [4:0] FS_ADD_DEF = 5'b01000;

    typedef struct packed {
        op_t         op;
        logic [4:0]  fs;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] imm;
    } cmd_t;

    typedef struct packed {
        logic        w;
        logic        en_b;
        logic        en_alu;
        logic        en_addr;
        logic        k_sel;
        logic        we;
        logic        oe;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic [4:0]  fs;
        logic [63:0] k;
    } ctl_t;

    function automatic logic is_mem(op_t o);
        return o[1];
    endfunction

endpackage

// File: rtl/ram_access_ctrl.sv
// Multi-cycle sequencer producing the RAM datapath control word.
// Outputs are registered from the next state and the latched command.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [4:0] FS_ADD      = FS_ADD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  fs_in,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [63:0] imm,
    output logic        busy,
    output logic        done,
    output logic        W,
    output logic        EN_B,
    output logic        EN_ALU,
    output logic        EN_ADDR,
    output logic        K_SEL,
    output logic        WE,
    output logic        OE,
    output logic        PC_SEL,
    output logic        C0,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic [4:0]  FS,
    output logic [63:0] K
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    cmd_t          cmd, cmd_nxt;
    ctl_t          ctl, ctl_nxt;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        cmd_nxt = cmd;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    cmd_nxt.op  = op_t'(op);
                    cmd_nxt.fs  = fs_in;
                    cmd_nxt.rd  = rd;
                    cmd_nxt.rn  = rn;
                    cmd_nxt.rm  = rm;
                    cmd_nxt.imm = imm;
                    nxt = is_mem(op_t'(op)) ? S_ADDR : S_EXEC;
                end
            end
            S_EXEC: nxt = S_DONE;
            S_ADDR: begin
                nxt     = S_MEM;
                cnt_nxt = CW'(WAIT_CYCLES - 1);
            end
            S_MEM: begin
                if (cnt == '0) nxt = S_DONE;
                else           cnt_nxt = cnt - 1'b1;
            end
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Control word for the state being entered, so it can be registered.
    always_comb begin
        ctl_nxt = '0;
        unique case (nxt)
            S_EXEC: begin
                ctl_nxt.sa     = cmd_nxt.rn;
                ctl_nxt.sb     = cmd_nxt.rm;
                ctl_nxt.fs     = cmd_nxt.fs;
                ctl_nxt.k      = cmd_nxt.imm;
                ctl_nxt.k_sel  = (cmd_nxt.op == OP_ALU_I);
                ctl_nxt.en_alu = 1'b1;
                ctl_nxt.w      = 1'b1;
                ctl_nxt.da     = cmd_nxt.rd;
            end
            S_ADDR, S_MEM: begin
                ctl_nxt.sa      = cmd_nxt.rn;
                ctl_nxt.k       = cmd_nxt.imm;
                ctl_nxt.k_sel   = 1'b1;
                ctl_nxt.fs      = FS_ADD;
                ctl_nxt.en_addr = 1'b1;
                if (nxt == S_MEM) begin
                    if (cmd_nxt.op == OP_STORE) begin
                        ctl_nxt.sb   = cmd_nxt.rm;
                        ctl_nxt.en_b = 1'b1;
                        ctl_nxt.we   = 1'b1;
                    end else begin
                        ctl_nxt.oe = 1'b1;
                        // RAM data is only valid on the bus in the last cycle
                        if (cnt_nxt == '0) begin
                            ctl_nxt.w  = 1'b1;
                            ctl_nxt.da = cmd_nxt.rd;
                        end
                    end
                end
            end
            default: ctl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            cmd   <= '0;
            ctl   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            cmd   <= cmd_nxt;
            ctl   <= ctl_nxt;
            busy  <= (nxt != S_IDLE);
            done  <= (nxt == S_DONE);
        end
    end

    assign W       = ctl.w;
    assign EN_B    = ctl.en_b;
    assign EN_ALU  = ctl.en_alu;
    assign EN_ADDR = ctl.en_addr;
    assign K_SEL   = ctl.k_sel;
    assign WE      = ctl.we;
    assign OE      = ctl.oe;
    assign SA      = ctl.sa;
    assign SB      = ctl.sb;
    assign DA      = ctl.da;
    assign FS      = ctl.fs;
    assign K       = ctl.k;
    assign PC_SEL  = 1'b0;
    assign C0      = 1'b0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: queue-based trace model, small datapath model,
// directed table, multi-cycle corner sequences and random traffic.
module tb_ram_access_ctrl;

    localparam logic [4:0] FS_ADD = 5'b01000;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        w;
        logic        en_b;
        logic        en_alu;
        logic        en_addr;
        logic        k_sel;
        logic        we;
        logic        oe;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic [4:0]  fs;
        logic [63:0] k;
    } word_t;

    typedef word_t wq_t[$];

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  fs;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] imm;
        int          lat1;
        int          lat3;
        bit          chk_mem;
        logic [63:0] where;
        logic [63:0] val;
    } vec_t;

    logic        clk, rst, start;
    logic [1:0]  op;
    logic [4:0]  fs_in, rd, rn, rm;
    logic [63:0] imm;

    logic        busy1, done1, w1, en_b1, en_alu1, en_addr1, k_sel1, we1, oe1, pc1, c01;
    logic [4:0]  sa1, sb1, da1, fs1;
    logic [63:0] k1;
    logic        busy3, done3, w3, en_b3, en_alu3, en_addr3, k_sel3, we3, oe3, pc3, c03;
    logic [4:0]  sa3, sb3, da3, fs3;
    logic [63:0] k3;

    ram_access_ctrl #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .fs_in(fs_in),
        .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .busy(busy1), .done(done1), .W(w1), .EN_B(en_b1), .EN_ALU(en_alu1),
        .EN_ADDR(en_addr1), .K_SEL(k_sel1), .WE(we1), .OE(oe1),
        .PC_SEL(pc1), .C0(c01), .SA(sa1), .SB(sb1), .DA(da1), .FS(fs1), .K(k1)
    );

    ram_access_ctrl #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .start(start), .op(op), .fs_in(fs_in),
        .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .busy(busy3), .done(done3), .W(w3), .EN_B(en_b3), .EN_ALU(en_alu3),
        .EN_ADDR(en_addr3), .K_SEL(k_sel3), .WE(we3), .OE(oe3),
        .PC_SEL(pc3), .C0(c03), .SA(sa3), .SB(sb3), .DA(da3), .FS(fs3), .K(k3)
    );

    word_t act1, act3, exp1, exp3;
    assign act1 = {busy1, done1, w1, en_b1, en_alu1, en_addr1, k_sel1,
                   we1, oe1, sa1, sb1, da1, fs1, k1};
    assign act3 = {busy3, done3, w3, en_b3, en_alu3, en_addr3, k_sel3,
                   we3, oe3, sa3, sb3, da3, fs3, k3};

    int checks = 0;
    int errors = 0;
    int done1_cnt = 0;
    bit started = 0;
    wq_t q1, q3;

    logic [63:0] r [32];
    logic [63:0] mem [logic [63:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    task automatic chk_w(input string name, input word_t a, input word_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    function automatic logic inv_ok(input logic w, eb, ea, ead, we, oe, pc, c0);
        return !(oe & (eb | ea)) && !(eb & ea) && (!(we | oe) || ead)
            && !(we & oe) && !(w & eb) && !pc && !c0;
    endfunction

    // Expected per-cycle control words for one command, ending in DONE then IDLE
    function automatic wq_t make_trace(input logic [1:0] o, input logic [4:0] f,
                                       input logic [4:0] d, input logic [4:0] a,
                                       input logic [4:0] b, input logic [63:0] im,
                                       input int n);
        wq_t t;
        word_t x, y;
        x = '0;
        x.busy = 1'b1;
        if (o == 2'b00 || o == 2'b01) begin
            x.sa = a; x.sb = b; x.fs = f; x.k = im;
            x.k_sel = (o == 2'b01); x.en_alu = 1'b1; x.w = 1'b1; x.da = d;
            t.push_back(x);
        end else begin
            x.sa = a; x.k = im; x.k_sel = 1'b1; x.fs = FS_ADD; x.en_addr = 1'b1;
            t.push_back(x);
            for (int i = 1; i <= n; i++) begin
                y = x;
                if (o == 2'b10) begin
                    y.oe = 1'b1;
                    if (i == n) begin
                        y.w = 1'b1;
                        y.da = d;
                    end
                end else begin
                    y.sb = b; y.en_b = 1'b1; y.we = 1'b1;
                end
                t.push_back(y);
            end
        end
        x = '0;
        x.busy = 1'b1;
        x.done = 1'b1;
        t.push_back(x);
        x = '0;
        t.push_back(x);
        return t;
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (!rst) begin
            q1.delete();
            q3.delete();
            exp1 = '0;
            exp3 = '0;
        end else begin
            if (q1.size() == 0 && start)
                q1 = make_trace(op, fs_in, rd, rn, rm, imm, 1);
            if (q3.size() == 0 && start)
                q3 = make_trace(op, fs_in, rd, rn, rm, imm, 3);
            exp1 = (q1.size() != 0) ? q1.pop_front() : word_t'('0);
            exp3 = (q3.size() != 0) ? q3.pop_front() : word_t'('0);
        end
    end

    logic [63:0] dp_a, dp_b, dp_f, dp_d;

    always @(negedge clk) begin
        if (started) begin
            chk_w("trace_w1", act1, exp1);
            chk_w("trace_w3", act3, exp3);
            chk("inv_w1", 64'(inv_ok(w1, en_b1, en_alu1, en_addr1, we1, oe1, pc1, c01)), 64'd1);
            chk("inv_w3", 64'(inv_ok(w3, en_b3, en_alu3, en_addr3, we3, oe3, pc3, c03)), 64'd1);
            if (done1) done1_cnt++;
            dp_a = r[sa1];
            dp_b = k_sel1 ? k1 : r[sb1];
            dp_f = (fs1 == FS_ADD) ? dp_a + dp_b : dp_a ^ dp_b;
            if (en_addr1 && we1) mem[dp_f] = r[sb1];
            dp_d = dp_f;
            if (oe1) dp_d = mem.exists(dp_f) ? mem[dp_f] : 64'h0;
            if (w1 && da1 != 5'd0) r[da1] = dp_d;
        end
    end

    vec_t tbl [4];
    int   l1, l3, cnt0;

    initial begin
        for (int i = 0; i < 32; i++) r[i] = 64'h0;
        r[1] = 64'd5;
        r[3] = 64'hDEAD;
        mem[64'h2000] = 64'h1111;

        tbl[0] = '{2'b01, FS_ADD, 5'd2, 5'd1, 5'd0, 64'd3, 2, 2, 1'b0, 64'd2, 64'd8};
        tbl[1] = '{2'b11, 5'd0, 5'd0, 5'd0, 5'd3, 64'h1004, 3, 5, 1'b1, 64'h1004, 64'hDEAD};
        tbl[2] = '{2'b10, 5'd0, 5'd4, 5'd0, 5'd0, 64'h1004, 3, 5, 1'b0, 64'd4, 64'hDEAD};
        tbl[3] = '{2'b00, FS_ADD, 5'd7, 5'd2, 5'd4, 64'h0, 2, 2, 1'b0, 64'd7, 64'hDEB5};

        rst = 1'b0; start = 1'b1; op = 2'b01; fs_in = FS_ADD;
        rd = 5'd2; rn = 5'd1; rm = 5'd0; imm = 64'd3;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy1), 64'd0);
        chk("reset_k_sel", 64'(k_sel1), 64'd0);

        for (int i = 0; i < 4; i++) begin
            rst = 1'b1; start = 1'b1;
            op = tbl[i].op; fs_in = tbl[i].fs; rd = tbl[i].rd;
            rn = tbl[i].rn; rm = tbl[i].rm; imm = tbl[i].imm;
            l1 = 0; l3 = 0;
            for (int n = 1; n <= 20 && (l1 == 0 || l3 == 0); n++) begin
                @(negedge clk);
                start = 1'b0;
                if (done1 && l1 == 0) l1 = n;
                if (done3 && l3 == 0) l3 = n;
            end
            @(negedge clk);
            chk($sformatf("lat_w1_%0d", i), 64'(l1), 64'(tbl[i].lat1));
            chk($sformatf("lat_w3_%0d", i), 64'(l3), 64'(tbl[i].lat3));
            if (tbl[i].chk_mem)
                chk($sformatf("mem_%0d", i), mem[tbl[i].where], tbl[i].val);
            else
                chk($sformatf("reg_%0d", i), r[tbl[i].where[4:0]], tbl[i].val);
        end

        // start held high while busy, inputs changing under it
        cnt0 = done1_cnt;
        start = 1'b1; op = 2'b01; fs_in = FS_ADD;
        rd = 5'd5; rn = 5'd1; rm = 5'd0; imm = 64'd7;
        for (int n = 0; n < 10 && !done1; n++) begin
            @(negedge clk);
            op = 2'($urandom); rd = 5'd6; rn = 5'd3; imm = 64'd100;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_done_count", 64'(done1_cnt - cnt0), 64'd1);
        chk("hold_r5", r[5], 64'd12);
        chk("hold_r6", r[6], 64'd0);

        // reset just before the STORE reaches its RAM cycle
        start = 1'b1; op = 2'b11; rd = 5'd0; rn = 5'd0; rm = 5'd3; imm = 64'h2000;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy1), 64'd0);
        chk("rst_mid_we", 64'(we1 | we3), 64'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_mid_mem", mem[64'h2000], 64'h1111);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 49) != 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 2'($urandom);
            fs_in = 5'($urandom);
            rd    = 5'($urandom);
            rn    = 5'($urandom);
            rm    = 5'($urandom);
            imm   = {$urandom, $urandom};
        end
        rst = 1'b1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("final_idle", 64'({busy1, busy3}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
